// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage has priority, debug/loader port gets a forced slot after MAX_WAIT losses.
// Optional: define DMEM_ARB_PERF_EN to add stall_cycles / dbg_grants saturating counters.
module dmem_arbiter #(
    parameter int AW       = 6,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_valid,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ready,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_rvalid,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_spo
`ifdef DMEM_ARB_PERF_EN
   ,output logic [31:0]   stall_cycles,
    output logic [31:0]   dbg_grants
`endif
);

    typedef enum logic {ST_ARB, ST_FORCE} arbState_t;

    arbState_t  state;
    logic [3:0] waitCnt;
    logic [4:0] waitNext;
    logic       cpuOwns;
    logic       dbgGrant;

    // In the forced slot the CPU only keeps the memory if debug withdrew its request.
    always_comb begin
        cpuOwns  = (state == ST_ARB) ? cpu_req : !dbg_valid;
        dbgGrant = dbg_valid & !cpuOwns;
        waitNext = {1'b0, waitCnt} + 5'd1;
    end

    assign cpu_rdata = mem_spo;
    assign cpu_stall = (state == ST_FORCE) & dbg_valid & cpu_req;
    assign dbg_ready = dbgGrant;
    assign mem_a     = cpuOwns ? cpu_addr  : dbg_addr;
    assign mem_d     = cpuOwns ? cpu_wdata : dbg_wdata;
    assign mem_we    = cpuOwns ? (cpu_req & cpu_we) : (dbg_valid & dbg_we);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_ARB;
            waitCnt    <= '0;
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            dbg_rvalid <= dbgGrant & !dbg_we;
            if (dbgGrant & !dbg_we)
                dbg_rdata <= mem_spo;
            case (state)
                ST_ARB: begin
                    if (dbg_valid & cpu_req) begin
                        if (waitNext == 5'(MAX_WAIT)) begin
                            state   <= ST_FORCE;
                            waitCnt <= '0;
                        end else begin
                            waitCnt <= waitNext[3:0];
                        end
                    end else begin
                        waitCnt <= '0;
                    end
                end
                default: begin
                    state   <= ST_ARB;
                    waitCnt <= '0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            dbg_grants   <= '0;
        end else begin
            if (cpu_stall && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (dbgGrant && dbg_grants != 32'hFFFF_FFFF)
                dbg_grants <= dbg_grants + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed test-plan scenarios followed by randomized traffic.
module tb_dmem_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;

    logic          clk, reset;
    logic          cpu_req, cpu_we, cpu_stall;
    logic [AW-1:0] cpu_addr, dbg_addr, mem_a;
    logic [DW-1:0] cpu_wdata, cpu_rdata, dbg_wdata, dbg_rdata, mem_d, mem_spo;
    logic          dbg_valid, dbg_we, dbg_ready, dbg_rvalid, mem_we;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]   stall_cycles, dbg_grants;
`endif

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
`ifdef DMEM_ARB_PERF_EN
       ,.stall_cycles(stall_cycles), .dbg_grants(dbg_grants)
`endif
    );

    // Memory the arbiter drives: async read, sync write.
    logic [DW-1:0] ram [2**AW];
    logic          ramClr;
    assign mem_spo = ram[mem_a];
    always @(posedge clk) begin
        if (ramClr) for (int k = 0; k < 2**AW; k++) ram[k] <= '0;
        else if (mem_we) ram[mem_a] <= mem_d;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cycleNo = 0;
    always @(posedge clk) cycleNo <= cycleNo + 1;

    int total = 0;
    int bad = 0;

    task automatic chkb(input string nm, input bit act, input bit exp);
        total++;
        if (act !== exp) begin bad++; $display("FAIL %s got=%0d want=%0d", nm, act, exp); end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin bad++; $display("FAIL %s got=%08h want=%08h", nm, act, exp); end
    endtask

    // Reference model: reference memory plus count of consecutive lost debug cycles.
    typedef struct { logic [DW-1:0] data; logic [31:0] cyc; } rdExp_t;
    logic [DW-1:0] refMem [2**AW];
    logic [2:0]    ctlQ [$];
    rdExp_t        rdQ [$];
    logic [DW-1:0] ldQ [$];
    int            losses = 0;
    int            mStalls = 0;
    int            mGrants = 0;

    task automatic drive(input bit cR, input bit cW, input logic [AW-1:0] cA, input logic [DW-1:0] cD,
                         input bit dV, input bit dW, input logic [AW-1:0] dA, input logic [DW-1:0] dD,
                         output bit dWin, output bit stall);
        bit cpuDo;
        rdExp_t r;
        cpu_req = cR; cpu_we = cW; cpu_addr = cA; cpu_wdata = cD;
        dbg_valid = dV; dbg_we = dW; dbg_addr = dA; dbg_wdata = dD;
        if (losses == MAX_WAIT) begin
            dWin = dV; stall = dV && cR; cpuDo = cR && !dV; losses = 0;
        end else begin
            dWin = dV && !cR; stall = 1'b0; cpuDo = cR;
            losses = (dV && cR) ? losses + 1 : 0;
        end
        ctlQ.push_back({dWin, stall, (dWin && dW) || (cpuDo && cW)});
        if (stall) mStalls++;
        if (dWin) begin
            mGrants++;
            if (dW) refMem[dA] = dD;
            else begin r.data = refMem[dA]; r.cyc = cycleNo + 1; rdQ.push_back(r); end
        end
        if (cpuDo) begin
            if (cW) refMem[cA] = cD;
            else ldQ.push_back(refMem[cA]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bit a, b;
        drive(0, 0, '0, '0, 0, 0, '0, '0, a, b);
    endtask

    // Monitor: compares whatever the DUT presents against queued expectations.
    always @(negedge clk) begin
        logic [2:0] e;
        rdExp_t r;
        if (!reset) begin
            if (ctlQ.size() > 0) begin
                e = ctlQ.pop_front();
                chkb("dbg_ready", dbg_ready, e[2]);
                chkb("cpu_stall", cpu_stall, e[1]);
                chkb("mem_we", mem_we, e[0]);
            end
            if (dbg_rvalid) begin
                if (rdQ.size() == 0) chkb("rvalid_unexpected", dbg_rvalid, 1'b0);
                else begin
                    r = rdQ.pop_front();
                    chkw("dbg_rdata", dbg_rdata, r.data);
                    chkw("rvalid_cycle", cycleNo, r.cyc);
                end
            end
            if (cpu_req && !cpu_we && !cpu_stall) begin
                if (ldQ.size() == 0) chkb("cpu_load_unexpected", 1'b1, 1'b0);
                else chkw("cpu_rdata", cpu_rdata, ldQ.pop_front());
            end
        end
    end

    initial begin
        bit dWin, stall, pend, cpuHold, cReqR, cWeR, dWeR;
        logic [AW-1:0] cAR, dAR;
        logic [DW-1:0] cDR, dDR, d;
        for (int k = 0; k < 2**AW; k++) refMem[k] = '0;
        reset = 1'b1; ramClr = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_valid = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chkb("rst_rvalid", dbg_rvalid, 1'b0);
        chkb("rst_ready", dbg_ready, 1'b0);
        chkb("rst_stall", cpu_stall, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chkw("rst_rdata", dbg_rdata, '0);
`ifdef DMEM_ARB_PERF_EN
        chkw("rst_stall_cycles", stall_cycles, '0);
        chkw("rst_dbg_grants", dbg_grants, '0);
`endif
        reset = 1'b0; ramClr = 1'b0;
        step();

        // Debug write then read of addr 5 with the CPU idle.
        drive(0, 0, '0, '0, 1, 1, 6'd5, 32'hDEADBEEF, dWin, stall);
        #1 chkb("dw_ready", dbg_ready, 1'b1); chkb("dw_mem_we", mem_we, 1'b1);
        step();
        drive(0, 0, '0, '0, 1, 0, 6'd5, '0, dWin, stall);
        #1 chkb("dr_ready", dbg_ready, 1'b1); chkb("dr_mem_we", mem_we, 1'b0);
        step();
        chkb("dr_rvalid", dbg_rvalid, 1'b1);
        chkw("dr_rdata", dbg_rdata, 32'hDEADBEEF);

        // Reset while the read pulse is still high.
        cpu_req = 0; dbg_valid = 0;
        reset = 1'b1;
        rdQ.delete(); losses = 0; mStalls = 0; mGrants = 0;
        #1;
        chkb("mid_rst_rvalid", dbg_rvalid, 1'b0);
        chkb("mid_rst_stall", cpu_stall, 1'b0);
        chkb("mid_rst_ready", dbg_ready, 1'b0);
        chkw("mid_rst_rdata", dbg_rdata, '0);
        @(posedge clk); #2 reset = 1'b0;
        step();

        // Starvation: four lost cycles, then a forced grant that stalls the CPU store.
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 5; i++) begin
                d = 32'h5000_0000 + 32'(rep * 16 + i);
                drive(1, 1, AW'(10 + i), d, 1, 1, AW'(40 + rep), 32'hA000_0000 + 32'(rep), dWin, stall);
                #1 chkb("starve_ready", dbg_ready, i == 4); chkb("starve_stall", cpu_stall, i == 4);
                step();
            end
            chkw("stalled_not_written", ram[14], refMem[14]);
            drive(1, 1, AW'(14), d, 0, 0, '0, '0, dWin, stall);
            #1 chkb("reissue_mem_we", mem_we, 1'b1);
            step();
            chkw("reissue_landed", ram[14], d);
            idle(); step();
        end
`ifdef DMEM_ARB_PERF_EN
        chkw("perf_stall_cycles", stall_cycles, 32'd3);
        chkw("perf_dbg_grants", dbg_grants, 32'd3);
`endif

        // CPU load of a preloaded word with no debug traffic.
        drive(0, 0, '0, '0, 1, 1, 6'd3, 32'h12345678, dWin, stall);
        step();
        drive(1, 0, 6'd3, '0, 0, 0, '0, '0, dWin, stall);
        #1 chkw("cpu_load", cpu_rdata, 32'h12345678); chkb("cpu_load_stall", cpu_stall, 1'b0);
        step();

        // Debug withdraws in the forced slot: CPU keeps the memory.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, AW'(20 + i), 32'h7700_0000 + 32'(i), 1, 0, 6'd7, '0, dWin, stall);
            step();
        end
        drive(1, 1, 6'd24, 32'h7700_0024, 0, 0, '0, '0, dWin, stall);
        #1 chkb("drop_stall", cpu_stall, 1'b0); chkb("drop_ready", dbg_ready, 1'b0);
        chkb("drop_mem_we", mem_we, 1'b1); chkw("drop_mem_a", 32'(mem_a), 32'd24);
        step();
        drive(1, 1, 6'd25, 32'h7700_0025, 1, 0, 6'd7, '0, dWin, stall);
        #1 chkb("back_in_arb", dbg_ready, 1'b0);
        step();
        drive(0, 0, '0, '0, 1, 0, 6'd7, '0, dWin, stall);
        step();
        idle(); step();

        // Random traffic; debug holds its request until accepted, a stalled CPU reissues.
        pend = 0; cpuHold = 0;
        cReqR = 0; cWeR = 0; cAR = '0; cDR = '0; dWeR = 0; dAR = '0; dDR = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(2) == 0) begin
                pend = 1; dWeR = 1'($urandom_range(1)); dAR = AW'($urandom_range(15)); dDR = $urandom;
            end
            if (!cpuHold) begin
                cReqR = ($urandom_range(9) < 7); cWeR = 1'($urandom_range(1));
                cAR = AW'($urandom_range(15)); cDR = $urandom;
            end
            drive(cReqR, cWeR, cAR, cDR, pend, dWeR, dAR, dDR, dWin, stall);
            if (dWin) pend = 0;
            cpuHold = stall;
            step();
        end
        repeat (3) begin idle(); step(); end

        chkw("ctlQ_drained", 32'(ctlQ.size()), 32'd0);
        chkw("rdQ_drained", 32'(rdQ.size()), 32'd0);
        chkw("ldQ_drained", 32'(ldQ.size()), 32'd0);
`ifdef DMEM_ARB_PERF_EN
        chkw("perf_stalls_total", stall_cycles, 32'(mStalls));
        chkw("perf_grants_total", dbg_grants, 32'(mGrants));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
